// File: rtl/clk_div_ctrl.sv
// Programmable clock divider: period/high-time pair with a one-deep pending update,
// glitch-free stop at the period boundary. Define CLK_DIV_CYCLE_CNT_EN to add cycle_cnt.
module clk_div_ctrl #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_ton,
    output logic             clk_out,
    output logic             rise_pulse,
    output logic             busy,
    output logic             cfg_err
`ifdef CLK_DIV_CYCLE_CNT_EN
    ,
    output logic [15:0]      cycle_cnt
`endif
);

    typedef enum logic [1:0] {StIdle, StRun, StStop} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] per_q, per_d;
    logic [CNT_W-1:0] ton_q, ton_d;
    logic [CNT_W-1:0] pend_per_q, pend_per_d;
    logic [CNT_W-1:0] pend_ton_q, pend_ton_d;
    logic             pend_vld_q, pend_vld_d;
    logic             clk_out_q, clk_out_d;
    logic             rise_q, rise_d;
    logic             err_q, err_d;
    logic             boundary;
    logic             cfg_acc;
    logic             cfg_legal;
    logic             apply_pend;

    assign boundary  = (cnt_q == per_q - CNT_W'(1));
    assign cfg_acc   = cfg_valid && !pend_vld_q;
    assign cfg_legal = (cfg_period >= CNT_W'(2)) && (cfg_ton != '0) && (cfg_ton < cfg_period);
    assign apply_pend = pend_vld_q && (boundary || state_q == StIdle);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a stop request only takes effect at a period boundary
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (en) state_d = StRun;
            StRun:  if (!en) state_d = boundary ? StIdle : StStop;
            StStop: begin
                if (en) begin
                    state_d = StRun;
                end else if (boundary) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Datapath next-state: configuration, phase counter, registered waveform
    always_comb begin
        per_d      = per_q;
        ton_d      = ton_q;
        pend_per_d = pend_per_q;
        pend_ton_d = pend_ton_q;
        pend_vld_d = pend_vld_q;
        err_d      = cfg_acc && !cfg_legal;

        if (apply_pend) begin
            per_d      = pend_per_q;
            ton_d      = pend_ton_q;
            pend_vld_d = 1'b0;
        end

        // cfg_acc requires an empty pending slot, so it never collides with apply_pend
        if (cfg_acc && cfg_legal) begin
            if (state_q == StIdle) begin
                per_d = cfg_period;
                ton_d = cfg_ton;
            end else begin
                pend_per_d = cfg_period;
                pend_ton_d = cfg_ton;
                pend_vld_d = 1'b1;
            end
        end

        if (state_q == StIdle || state_d == StIdle || boundary) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // Computed from next-cycle count and pair so clk_out lines up with cnt
        clk_out_d = (state_d != StIdle) && (cnt_d >= per_d - ton_d);
        rise_d    = clk_out_d && !clk_out_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            per_q      <= CNT_W'(2);
            ton_q      <= CNT_W'(1);
            pend_per_q <= '0;
            pend_ton_q <= '0;
            pend_vld_q <= 1'b0;
            clk_out_q  <= 1'b0;
            rise_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            per_q      <= per_d;
            ton_q      <= ton_d;
            pend_per_q <= pend_per_d;
            pend_ton_q <= pend_ton_d;
            pend_vld_q <= pend_vld_d;
            clk_out_q  <= clk_out_d;
            rise_q     <= rise_d;
            err_q      <= err_d;
        end
    end

    // Outputs
    always_comb begin
        busy       = (state_q != StIdle);
        cfg_ready  = !pend_vld_q;
        clk_out    = clk_out_q;
        rise_pulse = rise_q;
        cfg_err    = err_q;
    end

`ifdef CLK_DIV_CYCLE_CNT_EN
    logic [15:0] cyc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q <= 16'd0;
        end else if (rise_d) begin
            cyc_q <= cyc_q + 16'd1;
        end
    end

    assign cycle_cnt = cyc_q;
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl: defaults, reconfiguration, illegal configs,
// stop/restart behaviour and mid-period reset.
module tb_clk_div_ctrl;

    localparam int unsigned CNT_W = 8;

    logic             clk;
    logic             rst;
    logic             en;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CNT_W-1:0] cfg_period;
    logic [CNT_W-1:0] cfg_ton;
    logic             clk_out;
    logic             rise_pulse;
    logic             busy;
    logic             cfg_err;
`ifdef CLK_DIV_CYCLE_CNT_EN
    logic [15:0]      cycle_cnt;
`endif

    int checks = 0;
    int errors = 0;

    clk_div_ctrl #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_period (cfg_period),
        .cfg_ton    (cfg_ton),
        .clk_out    (clk_out),
        .rise_pulse (rise_pulse),
        .busy       (busy),
        .cfg_err    (cfg_err)
`ifdef CLK_DIV_CYCLE_CNT_EN
        ,
        .cycle_cnt  (cycle_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs are observed 1 ns after the edge; inputs changed here are sampled next edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic configure(input logic [CNT_W-1:0] p, input logic [CNT_W-1:0] t);
        cfg_valid  = 1'b1;
        cfg_period = p;
        cfg_ton    = t;
        step();
        cfg_valid  = 1'b0;
    endtask

    task automatic stop_to_idle();
        en = 1'b0;
        for (int n = 0; n < 40 && busy; n++) step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++; if (clk_out !== 1'b0) begin errors++; $display("FAIL reset_clk_out: got %b, expected 0", clk_out); end
        checks++; if (rise_pulse !== 1'b0) begin errors++; $display("FAIL reset_rise: got %b, expected 0", rise_pulse); end
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_cfg_err: got %b, expected 0", cfg_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready: got %b, expected 1", cfg_ready); end
        rst = 1'b0;
        step();
        checks++; if (busy !== 1'b0 || clk_out !== 1'b0) begin errors++; $display("FAIL idle_after_reset: busy=%b clk_out=%b, expected 0 0", busy, clk_out); end
    endtask

    task automatic test_default();
        logic exp;
        en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            exp = (i % 2 == 1);
            checks++; if (clk_out !== exp) begin errors++; $display("FAIL default_clk_out[%0d]: got %b, expected %b", i, clk_out, exp); end
            checks++; if (rise_pulse !== exp) begin errors++; $display("FAIL default_rise[%0d]: got %b, expected %b", i, rise_pulse, exp); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL default_busy[%0d]: got %b, expected 1", i, busy); end
        end
        stop_to_idle();
        checks++; if (busy !== 1'b0 || clk_out !== 1'b0) begin errors++; $display("FAIL default_stop: busy=%b clk_out=%b, expected 0 0", busy, clk_out); end
    endtask

    task automatic test_p10_t3();
        logic exp_clk;
        logic exp_rise;
        configure(8'd10, 8'd3);
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL p10_cfg_err: got %b, expected 0", cfg_err); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL p10_cfg_ready: got %b, expected 1", cfg_ready); end
        en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            exp_clk  = (i % 10 >= 7);
            exp_rise = (i % 10 == 7);
            checks++; if (clk_out !== exp_clk) begin errors++; $display("FAIL p10_clk_out[%0d]: got %b, expected %b", i, clk_out, exp_clk); end
            checks++; if (rise_pulse !== exp_rise) begin errors++; $display("FAIL p10_rise[%0d]: got %b, expected %b", i, rise_pulse, exp_rise); end
        end
        stop_to_idle();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL p10_stop: busy=%b, expected 0", busy); end
    endtask

    task automatic test_reconfig();
        logic exp_clk;
        logic exp_rise;
        configure(8'd10, 8'd3);
        en = 1'b1;
        for (int i = 0; i < 3; i++) step();
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reconfig_ready_before: got %b, expected 1", cfg_ready); end
        cfg_valid  = 1'b1;
        cfg_period = 8'd4;
        cfg_ton    = 8'd2;
        for (int i = 3; i < 10; i++) begin
            step();
            cfg_valid = 1'b0;
            exp_clk = (i >= 7);
            checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL reconfig_ready_low[cnt=%0d]: got %b, expected 0", i, cfg_ready); end
            checks++; if (clk_out !== exp_clk) begin errors++; $display("FAIL reconfig_old_clk[cnt=%0d]: got %b, expected %b", i, clk_out, exp_clk); end
        end
        for (int j = 0; j < 8; j++) begin
            step();
            exp_clk  = (j % 4 >= 2);
            exp_rise = (j % 4 == 2);
            checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reconfig_ready_high[%0d]: got %b, expected 1", j, cfg_ready); end
            checks++; if (clk_out !== exp_clk) begin errors++; $display("FAIL reconfig_new_clk[%0d]: got %b, expected %b", j, clk_out, exp_clk); end
            checks++; if (rise_pulse !== exp_rise) begin errors++; $display("FAIL reconfig_new_rise[%0d]: got %b, expected %b", j, rise_pulse, exp_rise); end
        end
        stop_to_idle();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reconfig_stop: busy=%b, expected 0", busy); end
    endtask

    task automatic test_illegal();
        logic exp_clk;
        logic exp_err;
        configure(8'd4, 8'd2);
        en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cfg_valid = 1'b0;
            if (i == 4) begin
                cfg_valid = 1'b1; cfg_period = 8'd5; cfg_ton = 8'd5;
            end else if (i == 8) begin
                cfg_valid = 1'b1; cfg_period = 8'd1; cfg_ton = 8'd0;
            end
            step();
            exp_clk = (i % 4 >= 2);
            exp_err = (i == 4) || (i == 8);
            checks++; if (cfg_err !== exp_err) begin errors++; $display("FAIL illegal_err[%0d]: got %b, expected %b", i, cfg_err, exp_err); end
            checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL illegal_ready[%0d]: got %b, expected 1", i, cfg_ready); end
            checks++; if (clk_out !== exp_clk) begin errors++; $display("FAIL illegal_clk[%0d]: got %b, expected %b", i, clk_out, exp_clk); end
        end
        cfg_valid = 1'b0;
        stop_to_idle();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL illegal_stop: busy=%b, expected 0", busy); end
    endtask

    task automatic test_stop_restart();
        logic exp_clk;
        configure(8'd8, 8'd4);
        en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            exp_clk = (i >= 4);
            checks++; if (clk_out !== exp_clk) begin errors++; $display("FAIL stop_clk[cnt=%0d]: got %b, expected %b", i, clk_out, exp_clk); end
        end
        en = 1'b0;
        step();
        checks++; if (busy !== 1'b1 || clk_out !== 1'b1) begin errors++; $display("FAIL stop_cnt6: busy=%b clk_out=%b, expected 1 1", busy, clk_out); end
        step();
        checks++; if (busy !== 1'b1 || clk_out !== 1'b1) begin errors++; $display("FAIL stop_cnt7: busy=%b clk_out=%b, expected 1 1", busy, clk_out); end
        step();
        checks++; if (busy !== 1'b0 || clk_out !== 1'b0) begin errors++; $display("FAIL stop_idle: busy=%b clk_out=%b, expected 0 0", busy, clk_out); end
        // en low sampled at cnt 3..5, back high when sampled at cnt 6
        for (int i = 0; i < 24; i++) begin
            en = !(i >= 4 && i <= 6);
            step();
            exp_clk = (i % 8 >= 4);
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL restart_busy[%0d]: got %b, expected 1", i, busy); end
            checks++; if (clk_out !== exp_clk) begin errors++; $display("FAIL restart_clk[%0d]: got %b, expected %b", i, clk_out, exp_clk); end
        end
        stop_to_idle();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL restart_stop: busy=%b, expected 0", busy); end
    endtask

    task automatic test_reset_mid();
        logic exp_clk;
        configure(8'd8, 8'd4);
        en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            cfg_valid = 1'b0;
            if (i == 2) begin
                cfg_valid = 1'b1; cfg_period = 8'd3; cfg_ton = 8'd1;
            end
            step();
            exp_clk = (i >= 4);
            checks++; if (clk_out !== exp_clk) begin errors++; $display("FAIL rstmid_clk[cnt=%0d]: got %b, expected %b", i, clk_out, exp_clk); end
        end
        cfg_valid = 1'b0;
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL rstmid_pending: cfg_ready=%b, expected 0", cfg_ready); end
        rst = 1'b1;
        step();
        checks++; if (clk_out !== 1'b0) begin errors++; $display("FAIL rstmid_clk_out: got %b, expected 0", clk_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b, expected 0", busy); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b, expected 1", cfg_ready); end
        rst = 1'b0;
        for (int j = 0; j < 6; j++) begin
            step();
            exp_clk = (j % 2 == 1);
            checks++; if (clk_out !== exp_clk) begin errors++; $display("FAIL rstmid_default_clk[%0d]: got %b, expected %b", j, clk_out, exp_clk); end
            checks++; if (rise_pulse !== exp_clk) begin errors++; $display("FAIL rstmid_default_rise[%0d]: got %b, expected %b", j, rise_pulse, exp_clk); end
        end
        stop_to_idle();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_stop: busy=%b, expected 0", busy); end
    endtask

    initial begin
        rst        = 1'b1;
        en         = 1'b0;
        cfg_valid  = 1'b0;
        cfg_period = '0;
        cfg_ton    = '0;
        test_reset();
        test_default();
        test_p10_t3();
        test_reconfig();
        test_illegal();
        test_stop_restart();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/clk_div_ctrl.md
CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of the period and high-time fields and of the phase counter.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port en, input, 1 bit: run request for the generated clock.
REQ-005 SHALL have port cfg_valid, input, 1 bit: a new configuration is offered.
REQ-006 SHALL have port cfg_ready, output, 1 bit: a configuration can be accepted this cycle.
REQ-007 SHALL have port cfg_period, input, CNT_W bits: period P in clk cycles.
REQ-008 SHALL have port cfg_ton, input, CNT_W bits: high time T in clk cycles.
REQ-009 SHALL have port clk_out, output, 1 bit: registered generated clock.
REQ-010 SHALL have port rise_pulse, output, 1 bit: registered; high only in the cycle clk_out goes 0->1.
REQ-011 SHALL have port busy, output, 1 bit: high when the state is not IDLE.
REQ-012 SHALL have port cfg_err, output, 1 bit: registered one-cycle pulse when an illegal configuration is rejected.

Function
REQ-013 SHALL use a state machine with states IDLE, RUN and STOP; busy is high in RUN and STOP.
REQ-014 SHALL hold an active pair (P, T) and a one-entry pending pair with a pending-valid flag.
REQ-015 SHALL treat a configuration as legal only when P >= 2 and 1 <= T <= P-1.
REQ-016 SHALL drive cfg_ready = !pending_valid, and accept a configuration only when cfg_valid && cfg_ready.
REQ-017 SHALL, for an accepted illegal configuration: pulse cfg_err for one cycle, leave active and pending unchanged, and not set pending_valid.
REQ-018 SHALL, for an accepted legal configuration: copy it into the active pair on the next edge when the state is IDLE; otherwise load it into pending.
REQ-019 SHALL clear the phase counter cnt to 0 in IDLE; in RUN and STOP cnt counts 0..P-1 and wraps to 0.
REQ-020 SHALL treat a period boundary as the cycle where cnt == P-1.
REQ-021 SHALL drive clk_out registered: low while cnt < P-T, high while cnt >= P-T (low phase first, then high phase).
REQ-022 SHALL, on a period boundary with pending_valid = 1: copy pending into the active pair, clear pending_valid, and start the next period with the new P and T.
REQ-023 SHALL, when a legal configuration is accepted on the same edge as a boundary apply, keep that configuration pending (cfg_ready is low then, so this cannot occur).
REQ-024 SHALL transition IDLE -> RUN when en = 1; the first RUN cycle has cnt = 0 and clk_out = 0.
REQ-025 SHALL transition RUN -> STOP when en = 0; the current period completes.
REQ-026 SHALL transition STOP -> IDLE at the period boundary, with clk_out = 0 on the next cycle; no truncated high phase is permitted.
REQ-027 SHALL transition STOP -> RUN when en returns to 1 before the boundary, with no gap and cnt continuing.
REQ-028 SHALL hold clk_out = 0 in IDLE at all times.

Reset
REQ-029 SHALL, on rst, set: state IDLE, cnt 0, active P = 2, active T = 1, pending_valid 0, clk_out 0, rise_pulse 0, cfg_err 0, busy 0, cfg_ready 1.
REQ-030 SHALL, when rst is asserted mid-period, drop clk_out to 0 on the next edge and discard any pending configuration.

Configuration
REQ-031 SHALL, with macro CLK_DIV_CYCLE_CNT_EN defined, add output cycle_cnt, 16 bits: it increments by 1 at each rising clk_out, wraps at 0xFFFF->0, and resets to 0 on rst.
REQ-032 SHALL, without CLK_DIV_CYCLE_CNT_EN, have no cycle_cnt port and no associated logic.

Verification
REQ-033 SHALL test: reset, then en = 1 with defaults -> clk_out toggles 0,1,0,1…; rise_pulse is high on each cycle with clk_out = 1.
REQ-034 SHALL test: in IDLE, configure P = 10, T = 3, then en = 1 -> 7 cycles low, 3 cycles high, repeating; rise_pulse every 10 cycles.
REQ-035 SHALL test: while running P = 10, T = 3, configure P = 4, T = 2 at cnt = 2 -> cfg_ready is low until the boundary; the old period finishes, then 2 low and 2 high.
REQ-036 SHALL test: configure P = 5, T = 5, and separately P = 1, T = 0 -> each gives one cfg_err pulse; the waveform is unchanged and cfg_ready stays high.
REQ-037 SHALL test: running P = 8, T = 4, drop en at cnt = 5 -> the high phase completes through cnt = 7, then IDLE and busy = 0; drop en again and reassert at cnt = 6 -> no gap.
REQ-038 SHALL test: rst at cnt = 6 during the high phase -> clk_out = 0 next cycle, active pair back to (2, 1), and the pending configuration discarded.
